// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light count display.
package traffic_pkg;

  localparam int CNT_W = 5;

  localparam int LIGHT_RED    = 0;
  localparam int LIGHT_GREEN  = 1;
  localparam int LIGHT_YELLOW = 2;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    PH_ONES = 1'b0,
    PH_TENS = 1'b1
  } phase_t;

  // gfedcba, active high, digits 0..9
  localparam logic [6:0] SEG7 [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic logic [1:0] bcd_tens(input logic [CNT_W-1:0] v);
    if (v >= CNT_W'(30))      bcd_tens = 2'd3;
    else if (v >= CNT_W'(20)) bcd_tens = 2'd2;
    else if (v >= CNT_W'(10)) bcd_tens = 2'd1;
    else                      bcd_tens = 2'd0;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to 7-segment (gfedcba) decoder; non-BCD codes go dark.
module seg7_decode
  import traffic_pkg::*;
(
  input  bcd_t       digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = '0;
    if (digit <= 4'd9) seg = SEG7[digit];
  end

endmodule

// File: rtl/traffic_count_display.sv
// Selects the active light's countdown, converts to BCD and scans a 2-digit
// 7-segment display. Optional yellow blink: TRAFFIC_DISP_YELLOW_BLINK_EN.
module traffic_count_display
  import traffic_pkg::*;
#(
  parameter int SCAN_DIV  = 4,
  parameter int BLINK_DIV = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             red,
  input  logic             green,
  input  logic             yellow,
  input  logic [CNT_W-1:0] count_red,
  input  logic [CNT_W-1:0] count_green,
  input  logic [CNT_W-1:0] count_yellow,
  output logic [6:0]       seg,
  output logic [1:0]       dig_sel,
  output logic             fault
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [2:0]       lights;
  logic [1:0]       n_on;
  logic [CNT_W-1:0] sel_val_d, sel_val_q;
  logic             blank1_d, blank1_q, fault_d, fault_q;
  logic [1:0]       tens_d, tens_q;
  bcd_t             ones_d, ones_q;
  logic             blank2_q;
  logic [SCAN_W-1:0] scan_d, scan_q;
  logic             scan_wrap;
  phase_t           phase_d, phase_q;
  bcd_t             digit;
  logic [6:0]       seg_dec, seg_d, seg_q;
  logic [1:0]       dig_sel_d, dig_sel_q;
  logic             blank_eff;

  // Stage 1: pick the count of the single active light, flag overlaps.
  always_comb begin
    lights               = '0;
    lights[LIGHT_RED]    = red;
    lights[LIGHT_GREEN]  = green;
    lights[LIGHT_YELLOW] = yellow;
    n_on      = {1'b0, red} + {1'b0, green} + {1'b0, yellow};
    sel_val_d = '0;
    blank1_d  = 1'b1;
    fault_d   = 1'b0;
    if (n_on == 2'd1) begin
      blank1_d = 1'b0;
      if (lights[LIGHT_RED])        sel_val_d = count_red;
      else if (lights[LIGHT_GREEN]) sel_val_d = count_green;
      else                          sel_val_d = count_yellow;
    end else if (n_on != 2'd0) begin
      fault_d = 1'b1;
    end
  end

  // Stage 2: binary to two BCD digits.
  always_comb begin
    tens_d = bcd_tens(sel_val_q);
    ones_d = bcd_t'(sel_val_q - CNT_W'(tens_d) * CNT_W'(10));
  end

  // Scan slot counter and digit phase.
  always_comb begin
    scan_wrap = (scan_q == SCAN_W'(SCAN_DIV - 1));
    scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
    phase_d   = phase_q;
    if (scan_wrap) phase_d = (phase_q == PH_ONES) ? PH_TENS : PH_ONES;
  end

`ifdef TRAFFIC_DISP_YELLOW_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic               yel1_d, yel1_q, yel2_q;
  logic [BLINK_W-1:0] blink_cnt_d, blink_cnt_q;
  logic               blink_off_d, blink_off_q;

  // Blink period counts full scan periods (tens slot wrapping back to ones).
  always_comb begin
    yel1_d      = (n_on == 2'd1) && yellow;
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    if (!yel1_q) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if (scan_wrap && phase_q == PH_TENS) begin
      if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
    blank_eff = blank2_q | (yel2_q & blink_off_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      yel1_q      <= 1'b0;
      yel2_q      <= 1'b0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      yel1_q      <= yel1_d;
      yel2_q      <= yel1_q;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
    end
  end
`else
  always_comb blank_eff = blank2_q;
`endif

  always_comb digit = (phase_q == PH_ONES) ? ones_q : bcd_t'({2'b00, tens_q});

  seg7_decode u_seg7_decode (
    .digit (digit),
    .seg   (seg_dec)
  );

  // Output register; tens slot stays dark when the tens digit is zero.
  always_comb begin
    seg_d     = '0;
    dig_sel_d = 2'b00;
    if (!blank_eff) begin
      if (phase_q == PH_ONES) begin
        seg_d     = seg_dec;
        dig_sel_d = 2'b01;
      end else if (tens_q != 2'd0) begin
        seg_d     = seg_dec;
        dig_sel_d = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_val_q <= '0;
      blank1_q  <= 1'b1;
      fault_q   <= 1'b0;
      tens_q    <= '0;
      ones_q    <= '0;
      blank2_q  <= 1'b1;
      scan_q    <= '0;
      phase_q   <= PH_ONES;
      seg_q     <= '0;
      dig_sel_q <= 2'b00;
    end else begin
      sel_val_q <= sel_val_d;
      blank1_q  <= blank1_d;
      fault_q   <= fault_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      blank2_q  <= blank1_q;
      scan_q    <= scan_d;
      phase_q   <= phase_d;
      seg_q     <= seg_d;
      dig_sel_q <= dig_sel_d;
    end
  end

  assign seg     = seg_q;
  assign dig_sel = dig_sel_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_traffic_count_display.sv
// Directed bench for traffic_count_display in its default build (SCAN_DIV=4).
module tb_traffic_count_display;

  logic       clk;
  logic       rst;
  logic       red, green, yellow;
  logic [4:0] count_red, count_green, count_yellow;
  logic [6:0] seg;
  logic [1:0] dig_sel;
  logic       fault;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int k        = 0;  // posedges since the last reset release

  traffic_count_display #(
    .SCAN_DIV  (4),
    .BLINK_DIV (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .red          (red),
    .green        (green),
    .yellow       (yellow),
    .count_red    (count_red),
    .count_green  (count_green),
    .count_yellow (count_yellow),
    .seg          (seg),
    .dig_sel      (dig_sel),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [6:0] exp_seg, input logic [1:0] exp_sel);
    chk({tag, ".seg"}, seg, exp_seg);
    chk({tag, ".dig_sel"}, {5'b0, dig_sel}, {5'b0, exp_sel});
  endtask

  initial begin
    rst = 1'b0;
    red = 1'b1; green = 1'b0; yellow = 1'b0;
    count_red = 5'd18; count_green = 5'd0; count_yellow = 5'd0;
    repeat (3) @(negedge clk);
    chk_disp("reset", 7'h00, 2'b00);
    chk("reset.fault", {6'b0, fault}, 7'd0);

    rst = 1'b1; k = 0;
    tick(2);  chk_disp("r18_pipe_blank", 7'h00, 2'b00);
    tick(1);  chk_disp("r18_ones", 7'h7F, 2'b01);
    chk("r18_fault", {6'b0, fault}, 7'd0);
    tick(2);  chk_disp("r18_tens", 7'h06, 2'b10);
    tick(3);  chk_disp("r18_tens_end", 7'h06, 2'b10);
    tick(1);  chk_disp("r18_ones_again", 7'h7F, 2'b01);

    // k=9: green 7
    red = 1'b0; green = 1'b1; count_green = 5'd7;
    tick(3);  chk_disp("g7_ones", 7'h07, 2'b01);
    tick(1);  chk_disp("g7_lz_blank", 7'h00, 2'b00);
    chk("g7_fault", {6'b0, fault}, 7'd0);

    // k=13: yellow 0
    green = 1'b0; yellow = 1'b1; count_yellow = 5'd0;
    tick(4);  chk_disp("y0_ones", 7'h3F, 2'b01);

    // k=17: red 31
    yellow = 1'b0; red = 1'b1; count_red = 5'd31;
    tick(3);  chk_disp("r31_ones", 7'h06, 2'b01);
    tick(1);  chk_disp("r31_tens", 7'h4F, 2'b10);

    // k=21: idle
    red = 1'b0;
    tick(3);  chk_disp("idle", 7'h00, 2'b00);
    chk("idle_fault", {6'b0, fault}, 7'd0);

    // k=24: red + green overlap
    red = 1'b1; green = 1'b1;
    tick(1);  chk("overlap_fault", {6'b0, fault}, 7'd1);
    tick(2);  chk_disp("overlap_blank", 7'h00, 2'b00);
    chk("overlap_fault_hold", {6'b0, fault}, 7'd1);

    // k=27: green only again
    red = 1'b0; count_green = 5'd7;
    tick(1);  chk("clean_fault", {6'b0, fault}, 7'd0);
    tick(5);  chk_disp("clean_g7_ones", 7'h07, 2'b01);

    // k=33: green 25
    count_green = 5'd25;
    tick(3);  chk_disp("g25_ones", 7'h6D, 2'b01);
    tick(1);  chk_disp("g25_tens", 7'h5B, 2'b10);

    // k=37: green 9
    count_green = 5'd9;
    tick(3);  chk_disp("g9_lz_blank", 7'h00, 2'b00);
    tick(1);  chk_disp("g9_ones", 7'h6F, 2'b01);

    // k=41: red 18, then reset while tens slot is displayed
    green = 1'b0; red = 1'b1; count_red = 5'd18;
    tick(4);  chk_disp("r18b_tens", 7'h06, 2'b10);
    rst = 1'b0;
    #1;
    chk_disp("midscan_reset", 7'h00, 2'b00);
    chk("midscan_reset.fault", {6'b0, fault}, 7'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_disp("reset_held", 7'h00, 2'b00);

    rst = 1'b1; k = 0;
    tick(2);  chk_disp("restart_pipe_blank", 7'h00, 2'b00);
    tick(1);  chk_disp("restart_ones", 7'h7F, 2'b01);
    tick(2);  chk_disp("restart_tens", 7'h06, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/traffic_count_display.md
Name: traffic_count_display

Overview:
Downstream consumer of the traffic-light controller. Takes its one-hot light outputs and three countdown counters, selects the count for the active light, converts it to two BCD digits and drives a time-multiplexed 2-digit 7-segment display. It also flags illegal light combinations. It sits between the controller and the board display pins.

Parameters:
SCAN_DIV, 4, clk cycles per digit scan slot (>=2)
BLINK_DIV, 8, scan periods per blink half-cycle (used only with the optional feature)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
red  input  1  red light active, from controller
green  input  1  green light active
yellow  input  1  yellow light active
count_red  input  5  red countdown value, 0..31
count_green  input  5  green countdown value
count_yellow  input  5  yellow countdown value
seg  output  7  segments gfedcba, active high
dig_sel  output  2  digit enable, one-hot active high; bit0 = ones, bit1 = tens
fault  output  1  more than one light asserted

Behaviour:
- Reset values (asynchronous, rst low): seg=0, dig_sel=2'b00, fault=0, scan counter=0, phase=0, digit registers=0, blank=1. Outputs go to reset values immediately, including mid-scan.
- Stage 1, registered, 1-cycle latency:
  - Exactly one light high: sel_val = that light's count; blank=0; fault=0.
  - No light high (controller IDLE): sel_val=0; blank=1; fault=0.
  - Two or more lights high: sel_val=0; blank=1; fault=1.
  - fault is non-sticky; it clears on the first clean sample.
- Stage 2, registered: tens = 3/2/1/0 for sel_val >=30/>=20/>=10/else; ones = sel_val - 10*tens. Width 5->4+2 bits, no overflow for 0..31. Total latency from inputs to digit registers is 2 cycles.
- Scan counter: counts 0..SCAN_DIV-1 and wraps. On wrap, phase toggles. Phase 0 selects ones; phase 1 selects tens.
- Output register, 1 cycle after phase change:
  - Phase 0: dig_sel=01, seg=decode(ones).
  - Phase 1: if tens==0 (leading-zero blank), dig_sel=00 and seg=0; otherwise dig_sel=10 and seg=decode(tens).
  - blank=1 forces dig_sel=00 and seg=0 in both phases.
- Segment codes 0-9: 3F,06,5B,4F,66,6D,7D,07,7F,6F. Nibbles above 9 are unreachable; decode them to 0.
- Input changes mid-scan are allowed; new digits appear at the next output update after 2-cycle latency. There is no tearing within a slot beyond that.

Optional Feature:
TRAFFIC_DISP_YELLOW_BLINK_EN
- Defined: a blink counter advances on each phase-1->0 wrap and toggles blink_off every BLINK_DIV scan periods.
  - While stage-1 selection is yellow and blink_off=1, the display is blanked (dig_sel=00, seg=0).
  - The blink counter resets to 0 (display on) on reset and whenever yellow is not the selected light.
- Undefined: no blink logic; the yellow count is displayed steadily like red and green.

Decomposition:
- Package traffic_pkg:
  - CNT_W=5
  - Light index constants LIGHT_RED/GREEN/YELLOW
  - SEG7 constant array for digits 0-9
  - BCD digit typedef (4-bit)
- Sub-module seg7_decode: combinational 4-bit BCD to 7-bit gfedcba. Instantiated once on the muxed digit.

Test Plan:
- rst low during phase 1 with red=1,count_red=18 -> same cycle seg=0, dig_sel=00, fault=0; after release, phase restarts at 0.
- red=1, count_red=18 held -> from cycle 3: phase 0 seg=7F dig_sel=01; phase 1 seg=06 dig_sel=10; each slot lasts SCAN_DIV=4 cycles.
- green=1, count_green=7 -> phase 0 seg=07 dig_sel=01; phase 1 dig_sel=00 seg=00 (leading-zero blank). yellow=1, count_yellow=0 -> phase 0 seg=3F.
- red=1, count_red=31 -> tens seg=4F, ones seg=06. Then all lights 0 -> within 3 cycles dig_sel=00, seg=00, fault=0.
- red=1 and green=1 -> fault=1 after 1 cycle, display blanked. Return to green only -> fault=0 next cycle.
- With TRAFFIC_DISP_YELLOW_BLINK_EN, yellow=1, count_yellow=3, BLINK_DIV=8 -> digits shown for 8 scan periods (64 cycles), blank for 64 cycles, repeating. Switching to red -> steady display immediately after pipeline latency.
